tu_pipe_arbiter: RTL and testbench
==================================

// Module: tu_pipe_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer sharing one fixed-latency transform pipe (PreTU or PostTU instance)
//   between NUM_REQ requesters. It grants one requester, pulses the pipe start, waits for the pipe's
//   done, then pulses a per-requester ack. A watchdog flags a pipe that never completes.
//   Sits between the tile-level schedulers and the shared PreTU/PostTU latency pipe.
// PARAMETERS
//   NUM_REQ    4   number of requesters (>=2)
//   ID_WIDTH   2   width of grant_id; must be >= clog2(NUM_REQ)
//   TIMEOUT    64  max cycles in WAIT before watchdog fires; 0 disables watchdog
//   CNT_WIDTH  8   watchdog counter width; must hold TIMEOUT
// PORTS
//   clk          in   1         clock, rising edge
//   rst_n        in   1         asynchronous active-low reset
//   req          in   NUM_REQ   level request per requester; held until its ack
//   ack          out  NUM_REQ   one-cycle pulse: granted job finished (or timed out)
//   grant_valid  out  1         a job is in flight on the pipe
//   grant_id     out  ID_WIDTH  index of requester owning the pipe (valid when grant_valid)
//   pipe_start   out  1         one-cycle start pulse to the pipe
//   pipe_busy    in   1         pipe busy flag
//   pipe_done    in   1         pipe one-cycle done pulse
//   err_clr      in   1         clears err_timeout
//   err_timeout  out  1         sticky: a job hit the watchdog
// BEHAVIOUR
//   Reset: state=IDLE; ack=0, grant_valid=0, grant_id=0, pipe_start=0, err_timeout=0, watchdog=0,
//     rr pointer last=NUM_REQ-1 (so req[0] has highest priority first). Reset mid-job abandons it, no ack.
//   All outputs registered. States: IDLE, WAIT.
//   IDLE: eligible = req & ~ack (requester whose ack is high this cycle is masked; it must drop req
//     the cycle it sees ack). If eligible!=0 and pipe_busy==0: winner = first set bit scanning from
//     last+1 upward with wrap; next edge: grant_id<=winner, last<=winner, grant_valid<=1,
//     pipe_start<=1 (exactly one cycle), watchdog<=0, state<=WAIT.
//     If pipe_busy==1: no grant, stay IDLE. pipe_done in IDLE ignored.
//   WAIT: pipe_start returns to 0 after one cycle. watchdog increments each WAIT cycle (saturating).
//     pipe_done==1 (including the cycle right after pipe_start, i.e. LATENCY=0 pipe):
//       next edge: ack[grant_id]<=1 for one cycle, grant_valid<=0, state<=IDLE.
//     TIMEOUT!=0 and watchdog==TIMEOUT-1 without pipe_done: same exit, ack pulses, err_timeout<=1.
//     pipe_done and timeout in same cycle: treated as done, no error.
//     req[grant_id] dropping during WAIT is ignored; job completes and ack still pulses.
//   Latency: req rises at cycle t (IDLE, pipe idle) -> pipe_start high t+1 -> pipe_done high at
//     t+2+LATENCY -> ack high at t+3+LATENCY. Min gap between starts = LATENCY+3 cycles.
//   err_timeout: set as above; cleared by err_clr the next edge; set wins over simultaneous clear.
//   grant_id holds last value while grant_valid=0. At most one ack bit high at any time.
// TESTING
//   T1 single req[2]=1, pipe LATENCY=4 -> pipe_start at t+1, ack=4'b0100 at t+7, one pulse, no re-grant.
//   T2 req=4'b1011 held, each drops after ack -> grant order 0,1,3, then req[0] re-raised -> 0 again.
//   T3 req[1] dropped mid-WAIT -> ack[1] still pulses once when pipe_done arrives; no second start.
//   T4 pipe_done tied 0, TIMEOUT=8 -> ack after 8 WAIT cycles, err_timeout=1 until err_clr pulse.
//   T5 pipe_busy forced 1 for 10 cycles with req=4'b0001 -> no pipe_start until busy drops, then start.
//   T6 rst_n low during WAIT -> all outputs 0 asynchronously; after release req[0] granted first.

Source files
------------

// File: rtl/tu_pipe_arbiter_if.sv
// Handshake bundle between the tile schedulers, the shared transform pipe and tu_pipe_arbiter.
// master = requester/pipe side, slave = the arbiter.
interface tu_pipe_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
);
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  ack;
    logic                grant_valid;
    logic [ID_WIDTH-1:0] grant_id;
    logic                pipe_start;
    logic                pipe_busy;
    logic                pipe_done;
    logic                err_clr;
    logic                err_timeout;

    modport master (
        output req, pipe_busy, pipe_done, err_clr,
        input  ack, grant_valid, grant_id, pipe_start, err_timeout
    );

    modport slave (
        input  req, pipe_busy, pipe_done, err_clr,
        output ack, grant_valid, grant_id, pipe_start, err_timeout
    );
endinterface

// File: rtl/tu_pipe_arbiter.sv
// Round-robin sequencer sharing one fixed-latency PreTU/PostTU pipe between NUM_REQ requesters,
// with a watchdog that retires a job whose pipe never signals done.
module tu_pipe_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    tu_pipe_arbiter_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam bit                   WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [0:0]           state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [ID_WIDTH-1:0]  grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]  last_q, last_d;
    logic                 pipe_start_q, pipe_start_d;
    logic [CNT_WIDTH-1:0] wd_q, wd_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   eligible, rot;
    logic [2*NUM_REQ-1:0] dbl;
    logic                 win_vld;
    logic [ID_WIDTH-1:0]  win_id;
    logic                 timeout_hit, err_set;

    // Rotate eligibility so bit 0 is the requester right after the last winner; lowest set bit wins.
    always_comb begin
        eligible = bus.req & ~ack_q;
        dbl      = {eligible, eligible} >> (int'(last_q) + 1);
        rot      = dbl[NUM_REQ-1:0];
        win_vld  = |rot;
        win_id   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) win_id = ID_WIDTH'((int'(last_q) + 1 + j) % NUM_REQ);
        end
    end

    assign timeout_hit = WD_EN && (wd_q == WD_LAST);

    always_comb begin
        state_d       = state_q;
        ack_d         = '0;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        last_d        = last_q;
        pipe_start_d  = 1'b0;
        wd_d          = wd_q;
        err_set       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_vld && !bus.pipe_busy) begin
                    grant_id_d    = win_id;
                    last_d        = win_id;
                    grant_valid_d = 1'b1;
                    pipe_start_d  = 1'b1;
                    wd_d          = '0;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_d = (&wd_q) ? wd_q : wd_q + 1'b1;
                // A done arriving on the timeout cycle still counts as a clean completion.
                if (bus.pipe_done || timeout_hit) begin
                    ack_d         = NUM_REQ'(1) << grant_id_q;
                    grant_valid_d = 1'b0;
                    state_d       = S_IDLE;
                    err_set       = !bus.pipe_done;
                end
            end
            default: state_d = S_IDLE;
        endcase
        err_d = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ack_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            last_q        <= ID_WIDTH'(NUM_REQ - 1);
            pipe_start_q  <= 1'b0;
            wd_q          <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            last_q        <= last_d;
            pipe_start_q  <= pipe_start_d;
            wd_q          <= wd_d;
            err_q         <= err_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.pipe_start  = pipe_start_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_tu_pipe_arbiter.sv
// Randomized + directed bench for tu_pipe_arbiter against a job-level reference model.
module tb_tu_pipe_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tu_pipe_arbiter_if #(.NUM_REQ(N), .ID_WIDTH(2)) bus ();

    tu_pipe_arbiter #(.NUM_REQ(N), .ID_WIDTH(2), .TIMEOUT(TO), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0, n_pass = 0;
    int cyc = 0;

    // reference model: one job in flight at most
    bit m_busy, m_start, m_err;
    int m_owner, m_last, m_ack, m_waited;

    // stimulus knobs and pipe model
    int raise_pct, drop_pct, busy_pct, never_pct, clr_pct, lat_lo, lat_hi;
    int done_at;
    int starts, acks, ack_cyc;
    int gq[$];
    int t0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = 1;
        return (i < 0) ? '0 : (one << i);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_start = 0; m_err = 0;
        m_owner = 0; m_last = N - 1; m_ack = -1; m_waited = 0;
        done_at = -1;
    endtask

    // advance the model over the cycle whose inputs are currently driven
    task automatic predict();
        logic [N-1:0] elig;
        int new_ack;
        bit new_start, set_err;
        new_ack = -1; new_start = 0; set_err = 0;
        if (!m_busy) begin
            elig = bus.req & ~onehot(m_ack);
            if (elig != 0 && !bus.pipe_busy) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (elig[c]) begin
                        m_owner = c; m_last = c;
                        break;
                    end
                end
                m_busy = 1; new_start = 1; m_waited = 0;
            end
        end else if (bus.pipe_done) begin
            new_ack = m_owner; m_busy = 0;
        end else if (m_waited == TO - 1) begin
            new_ack = m_owner; m_busy = 0; set_err = 1;
        end else begin
            m_waited++;
        end
        if (set_err) m_err = 1;
        else if (bus.err_clr) m_err = 0;
        m_ack = new_ack;
        m_start = new_start;
    endtask

    // sample one cycle after the edge, compare, then drive this cycle's inputs
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("ack",         bus.ack,         onehot(m_ack));
        chk("grant_valid", bus.grant_valid, m_busy);
        chk("grant_id",    bus.grant_id,    m_owner);
        chk("pipe_start",  bus.pipe_start,  m_start);
        chk("err_timeout", bus.err_timeout, m_err);
        if (bus.pipe_start) begin starts++; gq.push_back(int'(bus.grant_id)); end
        if (bus.ack != 0) begin acks++; if (ack_cyc < 0) ack_cyc = cyc; end

        if (m_start) begin
            if ($urandom_range(99) < never_pct) done_at = -1;
            else done_at = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
        end
        bus.pipe_done = (done_at == cyc);
        for (int i = 0; i < N; i++) begin
            if (m_ack == i) bus.req[i] = 1'b0;
            else if (bus.req[i] && m_busy && m_owner == i && $urandom_range(99) < drop_pct) bus.req[i] = 1'b0;
            else if (!bus.req[i] && !(m_busy && m_owner == i) && $urandom_range(99) < raise_pct) bus.req[i] = 1'b1;
        end
        bus.pipe_busy = ($urandom_range(99) < busy_pct);
        bus.err_clr   = ($urandom_range(99) < clr_pct);
    endtask

    task automatic tick();
        step();
        predict();
    endtask

    task automatic quiet(input int lat);
        raise_pct = 0; drop_pct = 0; busy_pct = 0; never_pct = 0; clr_pct = 0;
        lat_lo = lat; lat_hi = lat;
    endtask

    task automatic clr_stats();
        starts = 0; acks = 0; ack_cyc = -1;
        gq.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = '0; bus.pipe_busy = 0; bus.pipe_done = 0; bus.err_clr = 0;
        quiet(2);
        model_reset();
        clr_stats();
        repeat (2) @(negedge clk);
        chk("rst_ack",   bus.ack,         0);
        chk("rst_gv",    bus.grant_valid, 0);
        chk("rst_gid",   bus.grant_id,    0);
        chk("rst_start", bus.pipe_start,  0);
        chk("rst_err",   bus.err_timeout, 0);
        rst_n = 1'b1;
        predict();

        // T2: fresh pointer, 1011 held -> 0,1,3, then 0 again
        quiet(2); clr_stats();
        step(); bus.req = 4'b1011; predict();
        repeat (30) tick();
        step(); bus.req[0] = 1'b1; predict();
        repeat (10) tick();
        chk("t2_ngrants", gq.size(), 4);
        if (gq.size() == 4) begin
            chk("t2_g0", gq[0], 0); chk("t2_g1", gq[1], 1);
            chk("t2_g2", gq[2], 3); chk("t2_g3", gq[3], 0);
        end

        // T1: single req[2], latency 4 -> ack at t+7, one start
        quiet(4); clr_stats();
        step(); bus.req = 4'b0100; predict(); t0 = cyc;
        repeat (14) tick();
        chk("t1_ack_cyc", ack_cyc, t0 + 7);
        chk("t1_starts",  starts, 1);
        chk("t1_acks",    acks, 1);

        // T3: owner drops req mid-WAIT, ack still pulses once
        quiet(5); clr_stats();
        step(); bus.req = 4'b0010; predict();
        repeat (3) tick();
        step(); bus.req[1] = 1'b0; predict();
        repeat (12) tick();
        chk("t3_starts", starts, 1);
        chk("t3_acks",   acks, 1);

        // T4: pipe never completes -> ack after TO WAIT cycles, sticky error
        quiet(2); never_pct = 100; clr_stats();
        step(); bus.req = 4'b0001; predict(); t0 = cyc;
        repeat (12) tick();
        chk("t4_ack_cyc",    ack_cyc, t0 + 1 + TO);
        chk("t4_err_sticky", bus.err_timeout, 1);
        step(); bus.err_clr = 1'b1; predict();
        step(); predict();
        chk("t4_err_clear", bus.err_timeout, 0);

        // T5: pipe busy holds off the grant
        quiet(1); busy_pct = 100; clr_stats();
        step(); bus.req = 4'b0001; predict();
        repeat (9) tick();
        chk("t5_no_start", starts, 0);
        busy_pct = 0;
        repeat (8) tick();
        chk("t5_start", starts, 1);

        // random traffic, including latency-6 done coinciding with the timeout cycle
        raise_pct = 30; drop_pct = 3; busy_pct = 15; never_pct = 5; clr_pct = 5;
        lat_lo = 0; lat_hi = 6;
        repeat (1500) tick();

        // T6: async reset in the middle of a job
        quiet(4); clr_stats();
        bus.req = '0;
        for (int i = 0; i < 40 && (m_busy || m_ack >= 0); i++) tick();
        chk("t6_settled", m_busy, 0);
        step(); bus.req = 4'b0100; predict();
        tick(); tick();
        chk("t6_in_wait", bus.grant_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_ack",   bus.ack,         0);
        chk("t6_rst_gv",    bus.grant_valid, 0);
        chk("t6_rst_gid",   bus.grant_id,    0);
        chk("t6_rst_start", bus.pipe_start,  0);
        chk("t6_rst_err",   bus.err_timeout, 0);
        model_reset(); clr_stats();
        bus.req = '0; bus.pipe_busy = 0; bus.pipe_done = 0; bus.err_clr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.req = 4'b1111;
        predict();
        repeat (4) tick();
        chk("t6_ngrant", gq.size() > 0, 1);
        if (gq.size() > 0) chk("t6_first", gq[0], 0);
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
